// File: rtl/bidir_transceiver.sv
// Clocked bidirectional A/B transceiver with a programmable dead-time
// between direction changes and a saturating transfer counter.
module bidir_transceiver #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE,
    input  logic             SR,
    input  logic             CLR,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] AOUT,
    output logic [WIDTH-1:0] BOUT,
    output logic             OEA,
    output logic             OEB,
    output logic             DIR,
    output logic             BUSY,
    output logic [CNT_W-1:0] XFER_CNT
);

    localparam int TW = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TLOAD = TW'(TURN_CYCLES);
    localparam logic [TW-1:0] TONE  = TW'(1);

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        UP,
        DOWN
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             tgt_q, tgt_d;
    logic [WIDTH-1:0] aout_q, aout_d;
    logic [WIDTH-1:0] bout_q, bout_d;
    logic             oea_q, oea_d;
    logic             oeb_q, oeb_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] xcnt_q, xcnt_d;
    logic             xfer;

    function automatic state_t drive_state(input logic up);
        return up ? UP : DOWN;
    endfunction

    // Any direction request either opens a dead-time window or, with no
    // turnaround configured, goes straight to driving.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        tgt_d   = tgt_q;
        if (!CE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    tgt_d = SR;
                    if (TURN_CYCLES == 0) begin
                        state_d = drive_state(SR);
                    end else begin
                        state_d = TURN;
                        tcnt_d  = TLOAD;
                    end
                end
                TURN: begin
                    if (SR != tgt_q) begin
                        tgt_d  = SR;
                        tcnt_d = TLOAD;
                    end else if (tcnt_q <= TONE) begin
                        state_d = drive_state(tgt_q);
                    end else begin
                        tcnt_d = tcnt_q - TONE;
                    end
                end
                UP, DOWN: begin
                    if (SR != (state_q == UP)) begin
                        tgt_d = SR;
                        if (TURN_CYCLES == 0) begin
                            state_d = drive_state(SR);
                        end else begin
                            state_d = TURN;
                            tcnt_d  = TLOAD;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        xfer   = (state_d == UP) || (state_d == DOWN);
        bout_d = (state_d == UP) ? A : bout_q;
        aout_d = (state_d == DOWN) ? B : aout_q;
        oeb_d  = (state_d == UP);
        oea_d  = (state_d == DOWN);
        busy_d = (state_d == TURN);
        dir_d  = dir_q;
        if (state_d == UP) begin
            dir_d = 1'b1;
        end else if (state_d == DOWN) begin
            dir_d = 1'b0;
        end
        xcnt_d = xcnt_q;
        if (CLR) begin
            xcnt_d = '0;
        end else if (xfer && !(&xcnt_q)) begin
            xcnt_d = xcnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            tgt_q   <= 1'b0;
            aout_q  <= '0;
            bout_q  <= '0;
            oea_q   <= 1'b0;
            oeb_q   <= 1'b0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            xcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            tgt_q   <= tgt_d;
            aout_q  <= aout_d;
            bout_q  <= bout_d;
            oea_q   <= oea_d;
            oeb_q   <= oeb_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            xcnt_q  <= xcnt_d;
        end
    end

    assign AOUT     = aout_q;
    assign BOUT     = bout_q;
    assign OEA      = oea_q;
    assign OEB      = oeb_q;
    assign DIR      = dir_q;
    assign BUSY     = busy_q;
    assign XFER_CNT = xcnt_q;

endmodule

// File: tb/tb_bidir_transceiver.sv
// Bench for bidir_transceiver: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model.
module tb_bidir_transceiver;

    localparam int W  = 8;
    localparam int T  = 2;
    localparam int CW = 4;

    logic          CLK   = 1'b0;
    logic          RST_N = 1'b0;
    logic          CE    = 1'b0;
    logic          SR    = 1'b0;
    logic          CLR   = 1'b0;
    logic [W-1:0]  A     = '0;
    logic [W-1:0]  B     = '0;
    logic [W-1:0]  AOUT, BOUT;
    logic          OEA, OEB, DIR, BUSY;
    logic [CW-1:0] XFER_CNT;

    int vectors     = 0;
    int miscompares = 0;

    // Model: mode 0 = idle, 1 = dead time, 2 = driving toward m_tgt
    int           m_mode;
    bit           m_tgt;
    int           m_left;
    logic [W-1:0] m_aout, m_bout;
    bit           m_dir;
    int           m_cnt;

    always #5 CLK = ~CLK;

    bidir_transceiver #(
        .WIDTH      (W),
        .TURN_CYCLES(T),
        .CNT_W      (CW)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .CE      (CE),
        .SR      (SR),
        .CLR     (CLR),
        .A       (A),
        .B       (B),
        .AOUT    (AOUT),
        .BOUT    (BOUT),
        .OEA     (OEA),
        .OEB     (OEB),
        .DIR     (DIR),
        .BUSY    (BUSY),
        .XFER_CNT(XFER_CNT)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_tgt  = 1'b0;
        m_left = 0;
        m_aout = '0;
        m_bout = '0;
        m_dir  = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_step();
        if (!CE) begin
            m_mode = 0;
        end else if (m_mode == 0 || SR != m_tgt) begin
            m_tgt  = SR;
            m_left = T;
            m_mode = (T == 0) ? 2 : 1;
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) m_mode = 2;
        end
        if (m_mode == 2) begin
            if (m_tgt) m_bout = A;
            else m_aout = B;
            m_dir = m_tgt;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
        if (CLR) m_cnt = 0;
    endtask

    task automatic check_all();
        chk("AOUT", 32'(AOUT), 32'(m_aout));
        chk("BOUT", 32'(BOUT), 32'(m_bout));
        chk("OEA", 32'(OEA), 32'(m_mode == 2 && !m_tgt));
        chk("OEB", 32'(OEB), 32'(m_mode == 2 && m_tgt));
        chk("BUSY", 32'(BUSY), 32'(m_mode == 1));
        chk("DIR", 32'(DIR), 32'(m_dir));
        chk("XFER_CNT", 32'(XFER_CNT), 32'(m_cnt));
        chk("OE_EXCL", 32'(OEA & OEB), 32'd0);
    endtask

    task automatic cycle();
        @(posedge CLK);
        if (!RST_N) model_reset();
        else model_step();
        @(negedge CLK);
        check_all();
    endtask

    // Called just after a falling edge; asserts reset mid-phase.
    task automatic async_reset();
        #2 RST_N = 1'b0;
        #1 model_reset();
        check_all();
        cycle();
        RST_N = 1'b1;
    endtask

    initial begin
        model_reset();
        #2 check_all();
        cycle();
        cycle();
        RST_N = 1'b1;

        // Up path
        CE = 1'b1; SR = 1'b1; A = 8'hAA;
        cycle();
        chk("busy_1", 32'(BUSY), 32'd1);
        cycle();
        chk("busy_2", 32'(BUSY), 32'd1);
        chk("oeb_early", 32'(OEB), 32'd0);
        cycle();
        chk("oeb_first", 32'(OEB), 32'd1);
        chk("bout_aa", 32'(BOUT), 32'hAA);
        A = 8'h55;
        cycle();
        chk("bout_55", 32'(BOUT), 32'h55);

        // Turnaround to down
        SR = 1'b0; B = 8'h3C;
        cycle();
        chk("oeb_fall", 32'(OEB), 32'd0);
        cycle();
        cycle();
        chk("oea_up", 32'(OEA), 32'd1);
        chk("aout_3c", 32'(AOUT), 32'h3C);
        chk("bout_hold", 32'(BOUT), 32'h55);

        // Retarget inside the dead time
        SR = 1'b1;
        cycle();
        SR = 1'b0;
        cycle();
        SR = 1'b1;
        cycle();
        cycle();
        chk("retgt_wait", 32'(BUSY), 32'd1);
        cycle();
        chk("retgt_oeb", 32'(OEB), 32'd1);
        chk("retgt_dir", 32'(DIR), 32'd1);

        // Disable
        CE = 1'b0; SR = 1'b0; A = 8'hFF; B = 8'hFF;
        repeat (10) cycle();
        CE = 1'b1;
        repeat (5) cycle();
        chk("down_on", 32'(OEA), 32'd1);
        CE = 1'b0;
        cycle();
        chk("down_off", 32'(OEA), 32'd0);

        // Saturating counter and clear priority
        CLR = 1'b1;
        cycle();
        CLR = 1'b0; CE = 1'b1; SR = 1'b1;
        repeat (20) cycle();
        chk("cnt_sat", 32'(XFER_CNT), 32'hF);
        CLR = 1'b1;
        cycle();
        chk("cnt_clr", 32'(XFER_CNT), 32'd0);
        CLR = 1'b0;

        // CE fall beats SR flip
        CE = 1'b0; SR = 1'b0;
        cycle();
        chk("ce_wins", 32'(BUSY), 32'd0);
        CE = 1'b1;
        cycle();
        chk("from_idle", 32'(BUSY), 32'd1);

        // Reset mid-UP
        SR = 1'b1; A = 8'hAA;
        repeat (4) cycle();
        async_reset();
        chk("rst_bout", 32'(BOUT), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            CE  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 5) == 0) SR = ~SR;
            CLR = ($urandom_range(0, 19) == 0);
            A   = W'($urandom);
            B   = W'($urandom);
            if ($urandom_range(0, 99) == 0) async_reset();
            else cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bidir_transceiver.md
Name: bidir_transceiver

Overview:
Clocked, parametrised successor to the 8-bit combinational bidirectional buffer. It moves WIDTH-bit data between port A and port B in the direction selected by SR, gated by CE. All outputs are registered. Direction changes go through a programmable dead-time (turnaround) window in which neither side drives, so the shared external bus never has contention. A saturating transfer counter is included for link bring-up and debug.

Parameters:
WIDTH, 8, data width of A/B/AOUT/BOUT
TURN_CYCLES, 2, dead cycles between enabling a direction and driving it (0 = no turnaround)
CNT_W, 16, width of transfer counter XFER_CNT

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
CE  input  1  chip enable; 0 forces IDLE
SR  input  1  direction: 1 = A->B (up), 0 = B->A (down)
CLR  input  1  synchronous clear of XFER_CNT
A  input  WIDTH  side-A data in
B  input  WIDTH  side-B data in
AOUT  output  WIDTH  registered data toward side A
BOUT  output  WIDTH  registered data toward side B
OEA  output  1  AOUT valid / side-A driver enable
OEB  output  1  BOUT valid / side-B driver enable
DIR  output  1  registered direction of last completed turnaround
BUSY  output  1  high in TURN state
XFER_CNT  output  CNT_W  words passed since reset/CLR, saturating

Behaviour:
- Reset (RST_N=0, asynchronous): state IDLE; AOUT=0, BOUT=0, OEA=0, OEB=0, DIR=0, BUSY=0, XFER_CNT=0. Outputs stay at these values while RST_N is low. Release is sampled on the next rising CLK.
- States: IDLE, TURN, UP, DOWN. Target direction TGT is captured from SR on entry to TURN. The turnaround counter is at least clog2(TURN_CYCLES+1) bits.
- IDLE:
  - CE=1 and TURN_CYCLES>0 -> TURN, load counter = TURN_CYCLES, TGT<=SR.
  - CE=1 and TURN_CYCLES=0 -> UP if SR=1, else DOWN.
  - CE=0 -> stay in IDLE.
- TURN:
  - OEA=OEB=0, BUSY=1. The counter decrements each edge; the state lasts exactly TURN_CYCLES cycles, then the next edge enters UP (TGT=1) or DOWN (TGT=0).
  - SR != TGT while in TURN: restart the window (reload the counter, TGT<=SR).
  - CE=0: go to IDLE.
- UP:
  - Every edge: BOUT<=A, OEB=1, OEA=0, DIR=1, XFER_CNT increments.
  - The edge that enters UP also captures A, so A->BOUT latency is 1 cycle.
- DOWN: mirror of UP. AOUT<=B, OEA=1, OEB=0, DIR=0, XFER_CNT increments.
- Exit from UP/DOWN:
  - CE=0: next edge -> IDLE, OEA=OEB=0.
  - SR flips with CE=1: next edge -> TURN (or straight to the opposite state if TURN_CYCLES=0), OEA=OEB=0.
- AOUT/BOUT hold their last captured value when not being updated; they are never cleared except by reset.
- OEA and OEB are never high together, in any state or cycle.
- Total delay from CE sampled high to first OE: TURN_CYCLES+1 edges.
- XFER_CNT:
  - Saturates at all-ones and does not wrap.
  - CLR=1 zeroes it on the next edge and has priority over increment on the same edge.
- Simultaneous CE fall and SR flip: CE wins, next state is IDLE.
- Reset mid-transfer or mid-TURN: immediate return to reset values. No partial data is retained.

Test Plan:
- Reset: drive RST_N=0 mid-UP with A=8'hAA -> AOUT=BOUT=0, OEA=OEB=0, XFER_CNT=0 immediately, without waiting for a clock edge.
- Up path (WIDTH=8, TURN_CYCLES=2): CE=1, SR=1, A=8'hAA from IDLE -> BUSY for 2 cycles, then OEB=1 and BOUT=8'hAA on edge 3. Change A to 8'h55 -> BOUT=8'h55 one edge later; OEA stays 0.
- Turnaround: in UP, set SR=0, B=8'h3C -> OEB falls next edge, BUSY high 2 cycles with OEA=OEB=0, then OEA=1 and AOUT=8'h3C. BOUT holds 8'h55.
- Retarget: during TURN toggle SR twice -> window restarts on each toggle; final state matches the last SR value; no OE glitch.
- Disable: CE=0 (with SR=0, both buses 8'hFF) from IDLE for 10 cycles -> OEA=OEB=0 and XFER_CNT unchanged. CE falls while in DOWN -> IDLE next edge.
- Counter: CNT_W=4, stay in UP 20 cycles -> XFER_CNT saturates at 4'hF. Then pulse CLR together with an increment edge -> XFER_CNT=0.
